// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and requester indices for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

   localparam int REQ_A = 0;
   localparam int REQ_B = 1;
   localparam int REQ_C = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin chooser, first asserted request at or after the pointer
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   logic found;
   int   k;

   // scan requests starting at the pointer, wrapping, and keep the first hit
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = (int'(ptr_i) + i) % NUM_REQ;
         if (!found && req_i[k]) begin
            gnt_o[k] = 1'b1;
            idx_o    = IW'(k);
            found    = 1'b1;
         end
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port, one transaction in flight (optional watchdog: MEM_ARB_TIMEOUT_EN)
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ         = 3,
   parameter int ADDR_WIDTH      = 16,
   parameter int BUS_WIDTH_BYTES = 32,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_REQ-1:0]                   req_i,
   input  logic [NUM_REQ-1:0]                   we_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]        addr_i,
   input  logic [NUM_REQ*BUS_WIDTH_BYTES*8-1:0] wdata_i,
   output logic [NUM_REQ-1:0]                   gnt_o,
   output logic [NUM_REQ-1:0]                   done_o,
   output logic [BUS_WIDTH_BYTES*8-1:0]         rdata_o,
   output logic                                 mem_req_o,
   output logic                                 mem_we_o,
   output logic [ADDR_WIDTH-1:0]                mem_addr_o,
   output logic [BUS_WIDTH_BYTES*8-1:0]         mem_wdata_o,
   input  logic                                 mem_ack_i,
   input  logic [BUS_WIDTH_BYTES*8-1:0]         mem_rdata_i,
   output logic                                 busy_o,
   output logic                                 error_o
);

   localparam int DW = BUS_WIDTH_BYTES * 8;
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t          state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
   logic [IW-1:0]       owner_q, owner_d, ptr_q, ptr_d;
   logic                we_q, we_d, mem_req_q, mem_req_d, err_q, err_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DW-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IW-1:0]       pick_idx;
   logic                pick_any;

   rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   // watchdog counter, cleared whenever the FSM is outside an active memory request
   always_ff @(posedge clk) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`endif

   // state, latched transaction fields, pointer and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         done_q    <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         we_q      <= 1'b0;
         mem_req_q <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         we_q      <= we_d;
         mem_req_q <= mem_req_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   // next-state: arbitrate in IDLE, wait for ack (or watchdog) in ISSUE, retire in RESP
   always_comb begin
      state_d   = state_q;
      gnt_d     = '0;
      done_d    = '0;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      we_d      = we_q;
      mem_req_d = mem_req_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d     = '0;
`endif
      case (state_q)
         IDLE: if (pick_any) begin
            state_d = ISSUE;
            gnt_d   = pick_gnt;
            owner_d = pick_idx;
            we_d    = we_i[pick_idx];
            addr_d  = addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d = wdata_i[int'(pick_idx)*DW +: DW];
         end
         ISSUE: begin
            mem_req_d = 1'b1;
            if (mem_req_q && mem_ack_i) begin
               state_d          = RESP;
               mem_req_d        = 1'b0;
               done_d[owner_q]  = 1'b1;
               rdata_d          = we_q ? rdata_q : mem_rdata_i;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (mem_req_q) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  state_d         = RESP;
                  mem_req_d       = 1'b0;
                  done_d[owner_q] = 1'b1;
                  rdata_d         = '0;
                  err_d           = 1'b1;
               end
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
            ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign rdata_o     = rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign busy_o      = state_q != IDLE;
   assign error_o     = err_q;

endmodule
